dram_bank_ctrl: RTL and testbench
=================================

DRAM_BANK_CTRL -- requirements
Module: dram_bank_ctrl

Interface
REQ-001 SHALL have parameter BANK_ID, default 0, meaning constant driven on ba.
REQ-002 SHALL have parameter BURST_STEP, default 4, meaning column increment per rd/wr command (BL4).
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  bank request valid
- req_ready  out  1  request accepted when valid&ready
- req_id  in  `AXI_ID_WIDTH  transaction id
- req_ra  in  `DRAM_RA_WIDTH  row
- req_ca  in  `DRAM_CA_WIDTH  start column
- req_len  in  4  column commands minus 1
- req_wr  in  1  1=write, 0=read
- t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp  in  `T_*_WIDTH  timing values, cycles
- ref_pending  in  1  refresh due (level)
- ref_done  out  1  one-cycle pulse on refresh completion
- act_req, rd_req, wr_req, pre_req, ref_req  out  1 each  scheduler requests
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  in  1 each  scheduler grants
- ba  out  `DRAM_BA_WIDTH  bank address
- ra  out  `DRAM_RA_WIDTH  row address
- ca  out  `DRAM_CA_WIDTH  column address
- cur_id  out  `AXI_ID_WIDTH  id of the request in service

Function
REQ-005 SHALL implement states CLOSED, ACT_WAIT, OPEN, ACCESS, PRE_WAIT, REF_WAIT.
REQ-006 SHALL hold one request register; req_ready = register empty AND NOT ref_pending AND NOT rst.
REQ-007 SHALL assert at most one *_req per cycle, holding it with ra/ca/ba stable until the matching *_gnt.
REQ-008 SHALL treat a cycle with *_req and *_gnt both high as the command issue cycle (cycle n).
REQ-009 CLOSED with request stored: assert act_req, ra=req_ra; on act_gnt go to ACT_WAIT.
REQ-010 After ACT at cycle n: rd_req/wr_req no earlier than n+t_rcd; pre_req no earlier than n+t_ras.
REQ-011 ACCESS: issue req_len+1 rd or wr commands; ca starts at req_ca, adds BURST_STEP per grant, wraps modulo 2^`DRAM_CA_WIDTH.
REQ-012 On last rd grant at n: pre_req no earlier than n+t_rtp; last wr grant: no earlier than n+t_wtp.
REQ-013 After PRE grant at n: ACT or REF no earlier than n+t_rp; state CLOSED.
REQ-014 After REF grant at n: ref_done pulses at n+t_rfc; state CLOSED; next ACT no earlier than n+t_rfc.
REQ-015 Request register clears on the last rd/wr grant of a request.
REQ-016 Refresh priority: ref_pending with register empty -> precharge if open, then ref_req; an in-service request completes first.
REQ-017 Timing value 0 SHALL be treated as 1.
REQ-018 Counters saturate at 0; no counter underflow or wrap.

Reset
REQ-019 rst SHALL force state CLOSED, empty request register, all counters 0, all *_req, ref_done and req_ready low, ra/ca/cur_id 0, ba=BANK_ID, even mid-command.
REQ-020 req_ready SHALL first rise the cycle after rst deasserts.

Configuration
REQ-021 With `BK_OPEN_PAGE_EN defined: row stays open after access; row hit -> direct rd/wr (t_rcd already met); row miss -> PRE, then ACT.
REQ-022 Without `BK_OPEN_PAGE_EN: precharge issues after every request at the earliest legal cycle; the bank is CLOSED when idle.

Verification
REQ-023 Closed-page read, t_rcd=3, t_rtp=2, t_ras=6, grants immediate, ACT at cycle 10, len=0 -> RD at 13, PRE at 16.
REQ-024 Write len=2, ca=0x3FE, CA width 10 -> wr commands at ca 0x3FE, 0x002, 0x006; PRE at last WR+t_wtp.
REQ-025 Open-page build, two reads row 5 then row 5 -> second RD issues with no ACT; row 7 next -> PRE, ACT row 7.
REQ-026 ref_pending while row open, t_rfc=20, REF granted at 50 -> PRE first; ref_done pulse at 70; req_ready low until ref_pending drops.
REQ-027 Grant withheld 5 cycles -> act_req and ra held stable all 5 cycles.
REQ-028 rst asserted one cycle after a wr grant -> all outputs at reset values next cycle; no further *_req.

Source files
------------

// File: rtl/dram_bank_ctrl.sv
// dram_bank_ctrl -- single-bank DRAM command sequencer.
//
// Holds one request at a time, opens the row (ACT), issues req_len+1 column
// commands (RD or WR), and closes the row (PRE). It also runs refreshes when
// ref_pending is high. Each command is requested from an external scheduler
// with a *_req/*_gnt handshake. A cycle with both *_req and *_gnt high is the
// cycle the command issues. Every DRAM timing is counted from that cycle.
//
// Build option:
//   BK_OPEN_PAGE_EN  When defined, the row stays open after an access. A
//                    request to the same row issues RD/WR directly. A request
//                    to a different row (or a refresh) precharges first. When
//                    undefined, every request ends with a precharge at the
//                    earliest legal cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_id/ra/ca/len/wr       request payload (len = column commands - 1)
//   t_rcd..t_wtp              timing values in cycles (0 is treated as 1)
//   ref_pending / ref_done    refresh due (level) / refresh completed (pulse)
//   *_req / *_gnt             scheduler command requests and grants
//   ba, ra, ca, cur_id        command address and id of the request in service

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 8
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 8
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 8
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 8
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 8
`endif

module dram_bank_ctrl #(
  parameter int BANK_ID    = 0,
  parameter int BURST_STEP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [`AXI_ID_WIDTH-1:0]  req_id,
  input  logic [`DRAM_RA_WIDTH-1:0] req_ra,
  input  logic [`DRAM_CA_WIDTH-1:0] req_ca,
  input  logic [3:0]                req_len,
  input  logic                      req_wr,
  input  logic [`T_RCD_WIDTH-1:0]   t_rcd,
  input  logic [`T_RP_WIDTH-1:0]    t_rp,
  input  logic [`T_RAS_WIDTH-1:0]   t_ras,
  input  logic [`T_RFC_WIDTH-1:0]   t_rfc,
  input  logic [`T_RTP_WIDTH-1:0]   t_rtp,
  input  logic [`T_WTP_WIDTH-1:0]   t_wtp,
  input  logic                      ref_pending,
  output logic                      ref_done,
  output logic                      act_req,
  output logic                      rd_req,
  output logic                      wr_req,
  output logic                      pre_req,
  output logic                      ref_req,
  input  logic                      act_gnt,
  input  logic                      rd_gnt,
  input  logic                      wr_gnt,
  input  logic                      pre_gnt,
  input  logic                      ref_gnt,
  output logic [`DRAM_BA_WIDTH-1:0] ba,
  output logic [`DRAM_RA_WIDTH-1:0] ra,
  output logic [`DRAM_CA_WIDTH-1:0] ca,
  output logic [`AXI_ID_WIDTH-1:0]  cur_id
);

  localparam int ID_W = `AXI_ID_WIDTH;
  localparam int RA_W = `DRAM_RA_WIDTH;
  localparam int CA_W = `DRAM_CA_WIDTH;
  localparam int BA_W = `DRAM_BA_WIDTH;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = max2(max2(max2(`T_RCD_WIDTH, `T_RP_WIDTH),
                                   max2(`T_RAS_WIDTH, `T_RFC_WIDTH)),
                              max2(`T_RTP_WIDTH, `T_WTP_WIDTH));

  typedef enum logic [2:0] {
    CLOSED, ACT_WAIT, OPEN, ACCESS, PRE_WAIT, REF_WAIT
  } state_t;

  // A counter loaded at issue cycle n with t-1 reads 0 at cycle n+t.
  // A timing value of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic              vld_q, vld_d;
  logic              wr_q, wr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [RA_W-1:0]   row_q, row_d;
  logic [CA_W-1:0]   col_q, col_d;
  logic [3:0]        len_q, len_d;
  logic [CNT_W-1:0]  rcd_cnt_q, rcd_cnt_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic [CNT_W-1:0]  rw2pre_cnt_q, rw2pre_cnt_d;  // tRTP or tWTP after last column command
  logic [CNT_W-1:0]  rp_cnt_q, rp_cnt_d;
  logic [CNT_W-1:0]  rfc_cnt_q, rfc_cnt_d;

  logic row_hit;
  logic close_row;
  logic issue_ok;
  logic pre_ok;
  logic can_open;
  logic accept;

`ifdef BK_OPEN_PAGE_EN
  logic [RA_W-1:0] open_row_q, open_row_d;

  assign row_hit   = vld_q && (row_q == open_row_q);
  // An open row closes only on a miss, or for a refresh when nothing is stored.
  assign close_row = vld_q ? !row_hit : ref_pending;
`else
  assign row_hit   = 1'b0;
  assign close_row = 1'b1;
`endif

  assign req_ready = !vld_q && !ref_pending && !rst;
  assign accept    = req_valid && req_ready;

  // In ACT_WAIT the first column command goes out as soon as tRCD expires.
  // It does not wait for a state change, so RD/WR can land exactly at ACT+tRCD.
  assign issue_ok = (state_q == ACCESS) ||
                    ((state_q == ACT_WAIT) && (rcd_cnt_q == '0)) ||
                    ((state_q == OPEN) && row_hit);
  assign pre_ok   = (state_q == OPEN) && !row_hit && close_row &&
                    (ras_cnt_q == '0) && (rw2pre_cnt_q == '0);
  assign can_open = (state_q == CLOSED) && (rp_cnt_q == '0) && (rfc_cnt_q == '0);

  assign ba     = BA_W'(BANK_ID);
  assign ra     = row_q;
  assign ca     = col_q;
  assign cur_id = id_q;

  always_comb begin
    state_d      = state_q;
    vld_d        = vld_q;
    wr_d         = wr_q;
    id_d         = id_q;
    row_d        = row_q;
    col_d        = col_q;
    len_d        = len_q;
    rcd_cnt_d    = sat_dec(rcd_cnt_q);
    ras_cnt_d    = sat_dec(ras_cnt_q);
    rw2pre_cnt_d = sat_dec(rw2pre_cnt_q);
    rp_cnt_d     = sat_dec(rp_cnt_q);
    rfc_cnt_d    = sat_dec(rfc_cnt_q);
`ifdef BK_OPEN_PAGE_EN
    open_row_d   = open_row_q;
`endif
    act_req      = 1'b0;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    pre_req      = 1'b0;
    ref_req      = 1'b0;
    ref_done     = 1'b0;

    if (accept) begin
      vld_d = 1'b1;
      wr_d  = req_wr;
      id_d  = req_id;
      row_d = req_ra;
      col_d = req_ca;
      len_d = req_len;
    end

    // The branches below are mutually exclusive, so at most one command
    // request is raised per cycle.
    if (issue_ok) begin
      rd_req = !wr_q;
      wr_req = wr_q;
      if (wr_q ? wr_gnt : rd_gnt) begin
        col_d = col_q + CA_W'(BURST_STEP);
        if (len_q == 4'd0) begin
          vld_d        = 1'b0;
          state_d      = OPEN;
          rw2pre_cnt_d = wr_q ? load_val(CNT_W'(t_wtp)) : load_val(CNT_W'(t_rtp));
        end else begin
          len_d   = len_q - 4'd1;
          state_d = ACCESS;
        end
      end
    end else if (pre_ok) begin
      pre_req = 1'b1;
      if (pre_gnt) begin
        rp_cnt_d = load_val(CNT_W'(t_rp));
        state_d  = (load_val(CNT_W'(t_rp)) == '0) ? CLOSED : PRE_WAIT;
      end
    end else if (can_open) begin
      // A stored request is already in service, so it wins over a refresh.
      if (vld_q) begin
        act_req = 1'b1;
        if (act_gnt) begin
          rcd_cnt_d = load_val(CNT_W'(t_rcd));
          ras_cnt_d = load_val(CNT_W'(t_ras));
          state_d   = ACT_WAIT;
`ifdef BK_OPEN_PAGE_EN
          open_row_d = row_q;
`endif
        end
      end else if (ref_pending) begin
        ref_req = 1'b1;
        if (ref_gnt) begin
          rfc_cnt_d = load_val(CNT_W'(t_rfc));
          state_d   = REF_WAIT;
        end
      end
    end

    // PRE_WAIT exits as tRP expires, so the bank reads CLOSED at PRE+tRP.
    if ((state_q == PRE_WAIT) && (rp_cnt_q <= CNT_W'(1))) begin
      state_d = CLOSED;
    end

    if ((state_q == REF_WAIT) && (rfc_cnt_q == '0)) begin
      ref_done = 1'b1;
      state_d  = CLOSED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLOSED;
      vld_q        <= 1'b0;
      wr_q         <= 1'b0;
      id_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      len_q        <= '0;
      rcd_cnt_q    <= '0;
      ras_cnt_q    <= '0;
      rw2pre_cnt_q <= '0;
      rp_cnt_q     <= '0;
      rfc_cnt_q    <= '0;
`ifdef BK_OPEN_PAGE_EN
      open_row_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      wr_q         <= wr_d;
      id_q         <= id_d;
      row_q        <= row_d;
      col_q        <= col_d;
      len_q        <= len_d;
      rcd_cnt_q    <= rcd_cnt_d;
      ras_cnt_q    <= ras_cnt_d;
      rw2pre_cnt_q <= rw2pre_cnt_d;
      rp_cnt_q     <= rp_cnt_d;
      rfc_cnt_q    <= rfc_cnt_d;
`ifdef BK_OPEN_PAGE_EN
      open_row_q   <= open_row_d;
`endif
    end
  end

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Testbench for dram_bank_ctrl: a cycle table for a closed-page read and a
// refresh, plus directed sequences for write column wrap, a withheld grant,
// zero timing values, refresh during service, and reset mid-command.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 8
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 8
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 8
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 8
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 8
`endif

module tb_dram_bank_ctrl;
  localparam int ID_W = `AXI_ID_WIDTH;
  localparam int RA_W = `DRAM_RA_WIDTH;
  localparam int CA_W = `DRAM_CA_WIDTH;
  localparam int BA_W = `DRAM_BA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_wr;
  logic [ID_W-1:0] req_id, cur_id;
  logic [RA_W-1:0] req_ra, ra;
  logic [CA_W-1:0] req_ca, ca;
  logic [3:0] req_len;
  logic [`T_RCD_WIDTH-1:0] t_rcd;
  logic [`T_RP_WIDTH-1:0]  t_rp;
  logic [`T_RAS_WIDTH-1:0] t_ras;
  logic [`T_RFC_WIDTH-1:0] t_rfc;
  logic [`T_RTP_WIDTH-1:0] t_rtp;
  logic [`T_WTP_WIDTH-1:0] t_wtp;
  logic ref_pending, ref_done;
  logic act_req, rd_req, wr_req, pre_req, ref_req;
  logic act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [BA_W-1:0] ba;

  dram_bank_ctrl #(.BANK_ID(2), .BURST_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_ra(req_ra), .req_ca(req_ca), .req_len(req_len), .req_wr(req_wr),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc),
    .t_rtp(t_rtp), .t_wtp(t_wtp),
    .ref_pending(ref_pending), .ref_done(ref_done),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
    .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .ba(ba), .ra(ra), .ca(ca), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic auto_g;

  // Outputs seen in the last cycle: {ready, act, rd, wr, pre, ref, done}
  logic [6:0] ev_out;
  logic ev_act, ev_rd, ev_wr, ev_pre, ev_ref;
  logic [RA_W-1:0] ev_ra;
  logic [CA_W-1:0] ev_ca;
  logic [ID_W-1:0] ev_id;

  typedef struct packed {
    logic       v;
    logic       rp;
    logic [4:0] g;   // {act, rd, wr, pre, ref} grants
    logic [6:0] e;   // {ready, act, rd, wr, pre, ref, done}
  } vec_t;
  vec_t tab [15];

  int act_c, rd_c, wr_c, pre_c, ref_c, done_c, nw, rd_n;
  logic [CA_W-1:0] cas [3];
  logic seen, bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (auto_g) begin
      act_gnt = act_req; rd_gnt = rd_req; wr_gnt = wr_req;
      pre_gnt = pre_req; ref_gnt = ref_req;
    end
    ev_out = {req_ready, act_req, rd_req, wr_req, pre_req, ref_req, ref_done};
    ev_act = act_req && act_gnt;
    ev_rd  = rd_req && rd_gnt;
    ev_wr  = wr_req && wr_gnt;
    ev_pre = pre_req && pre_gnt;
    ev_ref = ref_req && ref_gnt;
    ev_ra  = ra;
    ev_ca  = ca;
    ev_id  = cur_id;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_g) begin
      act_gnt = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0; pre_gnt = 1'b0; ref_gnt = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send_req(input logic wr, input logic [RA_W-1:0] row,
                          input logic [CA_W-1:0] col, input logic [3:0] len,
                          input logic [ID_W-1:0] id);
    req_valid = 1'b1; req_wr = wr; req_ra = row; req_ca = col;
    req_len = len; req_id = id;
    cycle();
    chk("accept", 32'(ev_out[6]), 32'd1);
    req_valid = 1'b0;
  endtask

`ifdef BK_OPEN_PAGE_EN
  task automatic run_to_rd(output int n_act, output int n_pre,
                           output logic [RA_W-1:0] act_ra, output logic got);
    n_act = 0; n_pre = 0; act_ra = '0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (ev_act) begin n_act++; act_ra = ev_ra; end
      if (ev_pre) n_pre++;
      if (ev_rd) begin got = 1'b1; break; end
    end
  endtask
  int n_act, n_pre;
  logic [RA_W-1:0] a_ra;
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; auto_g = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_id = '0; req_ra = '0; req_ca = '0; req_len = '0;
    ref_pending = 1'b0;
    act_gnt = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0; pre_gnt = 1'b0; ref_gnt = 1'b0;
    t_rcd = 3; t_ras = 6; t_rtp = 2; t_wtp = 3; t_rp = 2; t_rfc = 4;

    cycle(); cycle();
    chk("rst_outputs", 32'(ev_out), 32'd0);
    chk("rst_ra", 32'(ev_ra), 32'd0);
    chk("rst_ca", 32'(ev_ca), 32'd0);
    chk("rst_id", 32'(ev_id), 32'd0);
    chk("rst_ba", 32'(ba), 32'd2);
    rst = 1'b0;

`ifdef BK_OPEN_PAGE_EN
    auto_g = 1'b1;
    send_req(1'b0, 14'd5, 10'h000, 4'd0, 4'd1);
    run_to_rd(n_act, n_pre, a_ra, seen);
    chk("op_rd1_seen", 32'(seen), 32'd1);
    chk("op_rd1_act", 32'(n_act), 32'd1);
    send_req(1'b0, 14'd5, 10'h040, 4'd0, 4'd2);
    run_to_rd(n_act, n_pre, a_ra, seen);
    chk("op_hit_seen", 32'(seen), 32'd1);
    chk("op_hit_no_act", 32'(n_act), 32'd0);
    chk("op_hit_no_pre", 32'(n_pre), 32'd0);
    send_req(1'b0, 14'd7, 10'h000, 4'd0, 4'd3);
    run_to_rd(n_act, n_pre, a_ra, seen);
    chk("op_miss_seen", 32'(seen), 32'd1);
    chk("op_miss_pre", 32'(n_pre), 32'd1);
    chk("op_miss_act", 32'(n_act), 32'd1);
    chk("op_miss_row", 32'(a_ra), 32'd7);
`else
    // Closed-page read (row 5, col 0x010, len 0), then a refresh with t_rfc=4.
    // ACT at 1, RD at 1+tRCD=4, PRE at 1+tRAS=7 (later than 4+tRTP=6).
    tab[0]  = {1'b1, 1'b0, 5'b00000, 7'b1000000};
    tab[1]  = {1'b0, 1'b0, 5'b10000, 7'b0100000};
    tab[2]  = {1'b0, 1'b0, 5'b00000, 7'b0000000};
    tab[3]  = {1'b0, 1'b0, 5'b00000, 7'b0000000};
    tab[4]  = {1'b0, 1'b0, 5'b01000, 7'b0010000};
    tab[5]  = {1'b0, 1'b0, 5'b00000, 7'b1000000};
    tab[6]  = {1'b0, 1'b0, 5'b00000, 7'b1000000};
    tab[7]  = {1'b0, 1'b0, 5'b00010, 7'b1000100};
    tab[8]  = {1'b0, 1'b0, 5'b00000, 7'b1000000};
    tab[9]  = {1'b0, 1'b1, 5'b00001, 7'b0000010};
    tab[10] = {1'b0, 1'b1, 5'b00000, 7'b0000000};
    tab[11] = {1'b0, 1'b1, 5'b00000, 7'b0000000};
    tab[12] = {1'b0, 1'b1, 5'b00000, 7'b0000000};
    tab[13] = {1'b0, 1'b1, 5'b00000, 7'b0000001};
    tab[14] = {1'b0, 1'b0, 5'b00000, 7'b1000000};

    req_wr = 1'b0; req_ra = 14'd5; req_ca = 10'h010; req_len = 4'd0; req_id = 4'd3;
    for (int i = 0; i < 15; i++) begin
      req_valid   = tab[i].v;
      ref_pending = tab[i].rp;
      {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = tab[i].g;
      cycle();
      chk($sformatf("vec%0d", i), 32'(ev_out), 32'(tab[i].e));
      if (i == 1) chk("vec_act_ra", 32'(ev_ra), 32'd5);
      if (i == 4) begin
        chk("vec_rd_ca", 32'(ev_ca), 32'h010);
        chk("vec_rd_id", 32'(ev_id), 32'd3);
      end
    end
    {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = 5'b0;

    // Write len=2 from col 0x3FE: the column wraps at 10 bits.
    auto_g = 1'b1;
    send_req(1'b1, 14'd9, 10'h3FE, 4'd2, 4'd7);
    act_c = -1; wr_c = -1; pre_c = -1; nw = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (ev_act) act_c = cyc;
      if (ev_wr) begin
        if (nw < 3) cas[nw] = ev_ca;
        if (nw == 0) chk("wr_id", 32'(ev_id), 32'd7);
        if (nw == 0) chk("wr_first_rcd", 32'(cyc - act_c), 32'd3);
        nw++;
        wr_c = cyc;
      end
      if (ev_pre) begin pre_c = cyc; break; end
    end
    chk("wr_count", 32'(nw), 32'd3);
    chk("wr_ca0", 32'(cas[0]), 32'h3FE);
    chk("wr_ca1", 32'(cas[1]), 32'h002);
    chk("wr_ca2", 32'(cas[2]), 32'h006);
    chk("wr_pre_wtp", 32'(pre_c - wr_c), 32'd3);
    idle(3);

    // Withheld ACT grant: act_req and ra hold for 5 cycles.
    auto_g = 1'b0;
    send_req(1'b0, 14'h1234, 10'h000, 4'd0, 4'd1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("hold%0d", k), 32'({ev_out[5], ev_ra}), 32'({1'b1, 14'h1234}));
    end
    auto_g = 1'b1;
    cycle();
    chk("hold_act_after", 32'(ev_act), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (ev_pre) begin seen = 1'b1; break; end
    end
    chk("hold_pre_seen", 32'(seen), 32'd1);
    idle(3);

    // Zero timing values behave as 1.
    t_rcd = 0; t_ras = 0; t_rtp = 0; t_rp = 0;
    send_req(1'b0, 14'd2, 10'h000, 4'd0, 4'd4);
    act_c = -1; rd_c = -1; pre_c = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ev_act) act_c = cyc;
      if (ev_rd) rd_c = cyc;
      if (ev_pre) begin pre_c = cyc; break; end
    end
    chk("zero_rcd", 32'(rd_c - act_c), 32'd1);
    chk("zero_rtp", 32'(pre_c - rd_c), 32'd1);
    t_rcd = 3; t_ras = 6; t_rtp = 2; t_rp = 2;
    idle(3);

    // Refresh raised while a request is in service (t_rfc=20).
    t_rfc = 20;
    send_req(1'b0, 14'd3, 10'h020, 4'd1, 4'd5);
    ref_pending = 1'b1;
    rd_n = 0; rd_c = -1; pre_c = -1; ref_c = -1; done_c = -1; bad = 1'b0;
    for (int k = 0; k < 120; k++) begin
      cycle();
      if (ev_out[6]) bad = 1'b1;
      if (ev_rd) begin rd_n++; rd_c = cyc; end
      if (ev_pre && pre_c < 0) pre_c = cyc;
      if (ev_ref) ref_c = cyc;
      if (ev_out[0]) begin done_c = cyc; break; end
    end
    chk("ref_rd_done_first", 32'(rd_n), 32'd2);
    chk("ref_pre_after_rd", 32'(rd_c < pre_c), 32'd1);
    chk("ref_after_pre", 32'(pre_c < ref_c), 32'd1);
    chk("ref_done_trfc", 32'(done_c - ref_c), 32'd20);
    chk("ref_ready_low", 32'(bad), 32'd0);
    ref_pending = 1'b0;
    cycle();
    chk("ref_ready_back", 32'(ev_out[6]), 32'd1);
    t_rfc = 4;
    idle(2);

    // Reset one cycle after a write grant.
    send_req(1'b1, 14'd1, 10'h100, 4'd3, 4'd6);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ev_wr) begin seen = 1'b1; break; end
    end
    chk("rstmid_wr_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    cycle();
    cycle();
    chk("rstmid_outputs", 32'(ev_out), 32'd0);
    chk("rstmid_addr", 32'({ev_ra, ev_ca, ev_id}), 32'd0);
    chk("rstmid_ba", 32'(ba), 32'd2);
    rst = 1'b0;
    bad = 1'b0;
    cycle();
    chk("rstmid_ready", 32'(ev_out[6]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (ev_out[5:1] != 5'b0) bad = 1'b1;
      cycle();
    end
    chk("rstmid_no_req", 32'(bad), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
